// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, widths and LFSR taps for the light game.
package game_pkg;
    typedef enum logic [2:0] {IDLE, ARM, PLAY, RESULT, DONE} state_t;
    localparam int LFSR_W = 9;
    localparam int LIGHT_W = 8;
    localparam int TAP_A = 8;
    localparam int TAP_B = 4;
endpackage

// File: rtl/light_randomizer_lfsr9.sv
// lfsr9: x^9+x^5+1 Fibonacci LFSR with XOR reseed and a zero guard.
module lfsr9
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);
    logic [LFSR_W-1:0] nxt;

    always_comb nxt = load ? value ^ load_val : {value[LFSR_W-2:0], value[TAP_A] ^ value[TAP_B]};

    // an all-zero state would lock up, so the seed stands in for it
    always_ff @(posedge clk)
        if (rst) value <= seed;
        else value <= (nxt == '0) ? seed : nxt;
endmodule

// File: rtl/light_randomizer.sv
// light_randomizer: round sequencer feeding random target lights to the hit/miss stage.
module light_randomizer
    import game_pkg::*;
#(
    parameter int          ROUND_CYCLES  = 50000000,
    parameter int          RESULT_CYCLES = 25000000,
    parameter int          MAX_ROUNDS    = 16,
    parameter logic [8:0]  LFSR_SEED     = 9'h1A5
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  token,
    input  logic        token_valid,
    input  logic        hit,
    output logic [7:0]  light,
    output logic        enable,
    output logic        round_active,
    output logic [3:0]  round_num,
    output logic [4:0]  score,
    output logic        last_hit,
    output logic        game_over
);
    localparam int TMAX = (ROUND_CYCLES > RESULT_CYCLES) ? ROUND_CYCLES : RESULT_CYCLES;
    localparam int TW = $clog2(TMAX);

    state_t             state;
    logic [TW-1:0]      timer;
    logic [LFSR_W-1:0]  lfsr;
    logic [LIGHT_W-1:0] cand;
    logic               play_end, result_end, last_round;

    lfsr9 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (token_valid),
        .load_val (token),
        .seed     (LFSR_SEED),
        .value    (lfsr)
    );

    assign cand         = (lfsr[LIGHT_W-1:0] == '0) ? 8'h01 : lfsr[LIGHT_W-1:0];
    assign enable       = state == ARM;
    assign round_active = state == PLAY;
    assign game_over    = state == DONE;
    assign play_end     = timer == TW'(ROUND_CYCLES - 1);
    assign result_end   = timer == TW'(RESULT_CYCLES - 1);
    assign last_round   = round_num == 4'(MAX_ROUNDS - 1);

    // light is latched on every entry into ARM so it is already valid while enable pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            light     <= '0;
            round_num <= '0;
            score     <= '0;
            last_hit  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= ARM;
                    light     <= cand;
                    score     <= '0;
                    round_num <= '0;
                    last_hit  <= 1'b0;
                end
                ARM: begin
                    state <= PLAY;
                    timer <= '0;
                end
                PLAY: if (hit) begin
                    state    <= RESULT;
                    timer    <= '0;
                    last_hit <= 1'b1;
                    score    <= score + 5'(score != 5'd31);
                end else if (play_end) begin
                    state    <= RESULT;
                    timer    <= '0;
                    last_hit <= 1'b0;
                end else begin
                    timer <= timer + TW'(1);
                end
                RESULT: if (result_end) begin
                    timer <= '0;
                    if (last_round) begin
                        state <= DONE;
                        light <= '0;
                    end else begin
                        state     <= ARM;
                        light     <= cand;
                        round_num <= round_num + 4'd1;
                    end
                end else begin
                    timer <= timer + TW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_light_randomizer.sv
// tb_light_randomizer: directed game sequence with a scoreboard of expected observations.
module tb_light_randomizer;
    import game_pkg::*;

    localparam logic [8:0] SEED = 9'h1A5;

    logic       clk, rst, start, token_valid, hit;
    logic [8:0] token;
    logic [7:0] light;
    logic       enable, round_active, last_hit, game_over;
    logic [3:0] round_num;
    logic [4:0] score;

    light_randomizer #(
        .ROUND_CYCLES(8), .RESULT_CYCLES(2), .MAX_ROUNDS(4), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .token(token), .token_valid(token_valid),
        .hit(hit), .light(light), .enable(enable), .round_active(round_active),
        .round_num(round_num), .score(score), .last_hit(last_hit), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {string tag; logic [31:0] exp;} exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [8:0] m;
    logic [7:0] exp_light;
    int ra_cnt, ena_cnt;
    logic light_ok;

    function automatic logic [8:0] model_next(logic [8:0] l, logic tv, logic [8:0] tok);
        logic [8:0] n;
        n = tv ? l ^ tok : {l[7:0], l[8] ^ l[4]};
        return (n == 9'd0) ? SEED : n;
    endfunction

    function automatic logic [7:0] cand_of(logic [8:0] l);
        return (l[7:0] == 8'd0) ? 8'h01 : l[7:0];
    endfunction

    task automatic tick;
        m = rst ? SEED : model_next(m, token_valid, token);
        @(posedge clk);
        #1;
    endtask

    task automatic push(string t, logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic pop_check(logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hit = 1'b0; token = '0; token_valid = 1'b0; m = SEED;
        // reset state
        tick;
        push("rst_light", 0); push("rst_enable", 0); push("rst_active", 0); push("rst_round", 0);
        push("rst_score", 0); push("rst_last_hit", 0); push("rst_game_over", 0);
        push("rst_state", IDLE); push("rst_lfsr", SEED);
        tick;
        pop_check(light); pop_check(enable); pop_check(round_active); pop_check(round_num);
        pop_check(score); pop_check(last_hit); pop_check(game_over);
        pop_check(dut.state); pop_check(dut.lfsr);
        rst = 1'b0;
        push("lfsr_step1", 9'h14B);
        tick;
        pop_check(dut.lfsr);
        for (int i = 0; i < 2; i++) begin
            tick;
            push("lfsr_step", m);
            pop_check(dut.lfsr);
        end
        // reseed: zero guard then plain XOR
        token = m; token_valid = 1'b1;
        push("reseed_zero", SEED);
        tick;
        pop_check(dut.lfsr);
        token = 9'h0FF;
        push("reseed_xor", SEED ^ 9'h0FF);
        tick;
        token_valid = 1'b0; token = '0;
        pop_check(dut.lfsr);
        // round 0: hit on the third play cycle
        start = 1'b1;
        exp_light = cand_of(m);
        push("arm_enable", 1); push("arm_light", exp_light); push("arm_light_nz", 1);
        tick;
        start = 1'b0;
        pop_check(enable); pop_check(light); pop_check(light != 8'd0);
        ena_cnt = enable; ra_cnt = 0; light_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            ra_cnt += round_active; ena_cnt += enable;
            light_ok &= (light == exp_light);
            if (i == 2) hit = 1'b1;
        end
        push("hit_active_cycles", 3); push("hit_enable_pulses", 1); push("hit_score", 1);
        push("hit_last", 1); push("hit_light_held", 1); push("hit_state", RESULT);
        tick;
        hit = 1'b0;
        ena_cnt += enable;
        light_ok &= (light == exp_light);
        pop_check(ra_cnt); pop_check(ena_cnt); pop_check(score);
        pop_check(last_hit); pop_check(light_ok); pop_check(dut.state);
        tick;
        exp_light = cand_of(m);
        push("next_arm_enable", 1); push("next_arm_round", 1); push("next_arm_light", exp_light);
        tick;
        pop_check(enable); pop_check(round_num); pop_check(light);
        // round 1: miss, full window
        ra_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            ra_cnt += round_active;
        end
        push("miss_active_cycles", 8); push("miss_active_off", 0);
        push("miss_last", 0); push("miss_score", 1);
        tick;
        pop_check(ra_cnt); pop_check(round_active); pop_check(last_hit); pop_check(score);
        push("miss_wait_enable", 0);
        tick;
        pop_check(enable);
        push("miss_next_arm", 1); push("miss_next_round", 2);
        tick;
        pop_check(enable); pop_check(round_num);
        // round 2: hit, then a hit during RESULT must be ignored
        tick;
        hit = 1'b1;
        push("r2_score", 2); push("r2_state", RESULT);
        tick;
        hit = 1'b0;
        pop_check(score); pop_check(dut.state);
        hit = 1'b1;
        push("result_hit_score", 2); push("result_hit_last", 1);
        tick;
        hit = 1'b0;
        pop_check(score); pop_check(last_hit);
        tick;
        // round 3: miss, then game over
        for (int i = 0; i < 10; i++) tick;
        push("done_game_over", 1); push("done_score", 2); push("done_round", 3);
        push("done_light", 0); push("done_enable", 0); push("done_state", DONE);
        tick;
        pop_check(game_over); pop_check(score); pop_check(round_num);
        pop_check(light); pop_check(enable); pop_check(dut.state);
        // restart from DONE
        start = 1'b1;
        push("restart_enable", 1); push("restart_score", 0); push("restart_round", 0);
        push("restart_game_over", 0); push("restart_last", 0);
        tick;
        start = 1'b0;
        pop_check(enable); pop_check(score); pop_check(round_num);
        pop_check(game_over); pop_check(last_hit);
        // hit on the timeout cycle counts
        ra_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            ra_cnt += round_active;
        end
        hit = 1'b1;
        push("timeout_cycles", 8); push("timeout_hit_last", 1);
        push("timeout_hit_score", 1); push("timeout_state", RESULT);
        tick;
        hit = 1'b0;
        pop_check(ra_cnt); pop_check(last_hit); pop_check(score); pop_check(dut.state);
        // reset in the middle of a play window
        tick; tick; tick; tick;
        rst = 1'b1;
        push("rst_mid_state", IDLE); push("rst_mid_score", 0); push("rst_mid_round", 0);
        push("rst_mid_active", 0); push("rst_mid_light", 0); push("rst_mid_lfsr", SEED);
        tick;
        rst = 1'b0;
        pop_check(dut.state); pop_check(score); pop_check(round_num);
        pop_check(round_active); pop_check(light); pop_check(dut.lfsr);
        // hit in IDLE is ignored
        hit = 1'b1;
        push("idle_hit_score", 0); push("idle_hit_last", 0); push("idle_hit_state", IDLE);
        tick; tick;
        hit = 1'b0;
        pop_check(score); pop_check(last_hit); pop_check(dut.state);
        push("lfsr_track", m);
        pop_check(dut.lfsr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
